// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   tx_state_t      : serializer FSM states
//   UART_*_OFS      : bus byte offsets of the TXDATA and STATUS registers
//   ST_*            : bit positions inside the STATUS register
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
  localparam logic [3:0] UART_STATUS_OFS = 4'h4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_IRQEN = 8;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Simple register bus between the CPU data port and the UART.
//   wr_en / rd_en : single-cycle strobes from the CPU
//   addr          : byte offset inside the UART window
//   wdata / rdata : write data to, registered read data from, the UART
interface uart_tx_mmio_if;
  logic        wr_en;
  logic        rd_en;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wr_en, rd_en, addr, wdata, input rdata);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, reusable by TX and RX paths.
//   clk, rst_n    : clock, asynchronous active-low reset (pointers only)
//   push, wdata   : write side; a push while full is ignored
//   pop, rdata    : read side; rdata shows the head entry while not empty
//   full, empty   : derived from pointers carrying an extra wrap bit
//   count         : number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU writes bytes into a TX FIFO and a
// baud-rate serializer drains them onto tx_o.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : register bus (TXDATA at 0x0, STATUS at 0x4), 1-cycle read latency
//   tx_o       : serial line, idle high
//   irq_o      : (only with UART_TX_IRQ_EN defined) irq_enable & empty & !busy
// Optional feature macro: UART_TX_IRQ_EN adds irq_o and STATUS bit8 irq_enable.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_mmio_if.slave bus,
  output logic          tx_o
`ifdef UART_TX_IRQ_EN
  ,
  output logic          irq_o
`endif
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  function automatic logic [3:0] sat_cnt(input logic [AW:0] c);
    if (int'(c) > 15) return 4'd15;
    return 4'(int'(c));
  endfunction

  tx_state_t   state, state_nxt;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_idx, bit_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        pop, push, full, empty, busy, ovf, tx_line;
  logic        wr_txdata, wr_status, ovf_set, ovf_clr;
  logic [7:0]  fifo_rdata;
  logic [AW:0] count;
  logic [31:0] status;
`ifdef UART_TX_IRQ_EN
  logic        irq_en;
`endif

  assign wr_txdata = bus.wr_en && (bus.addr == UART_TXDATA_OFS);
  assign wr_status = bus.wr_en && (bus.addr == UART_STATUS_OFS);
  // Full is sampled before any same-cycle pop, so a write while full drops.
  assign push      = wr_txdata && !full;
  assign ovf_set   = wr_txdata && full;
  assign ovf_clr   = wr_status && bus.wdata[ST_OVF];
  assign busy      = (state != IDLE);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.wdata[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    status            = '0;
    status[ST_FULL]   = full;
    status[ST_EMPTY]  = empty;
    status[ST_BUSY]   = busy;
    status[ST_OVF]    = ovf;
    status[7:4]       = sat_cnt(count);
`ifdef UART_TX_IRQ_EN
    status[ST_IRQEN]  = irq_en;
`endif
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_rdata;
          baud_nxt  = CW'(DIV - 1);
          state_nxt = START;
        end
      end
      START: begin
        if (baud_cnt == '0) begin
          baud_nxt  = CW'(DIV - 1);
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_nxt  = CW'(DIV - 1);
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 1'b1;
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_rdata;
            baud_nxt  = CW'(DIV - 1);
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    if (state == START)     tx_line = 1'b0;
    else if (state == DATA) tx_line = shift[0];
  end

  // Stage boundary: control state, line driver and read port register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      ovf       <= 1'b0;
      tx_o      <= 1'b1;
      bus.rdata <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      ovf      <= ovf_set | (ovf & ~ovf_clr);
      tx_o     <= tx_line;
      if (bus.rd_en) bus.rdata <= (bus.addr == UART_STATUS_OFS) ? status : '0;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      if (wr_status) irq_en <= bus.wdata[ST_IRQEN];
      irq_o <= irq_en & empty & ~busy;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with a line-decoding scoreboard.
// Uses a reduced baud divider (DIV=16) so every scenario stays short.
module tb_uart_tx_mmio;
  import uart_pkg::*;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 8;
  localparam int FRAME  = 10 * DIV;
`ifdef UART_TX_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
`ifdef UART_TX_IRQ_EN
  logic irq;
`endif

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave),
    .tx_o  (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq_o (irq)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [7:0]  exp_q[$];
  int unsigned start_q[$];
  int          frames   = 0;
  int          accepted = 0;
  logic        mon_act  = 1'b0;
  int          mon_t    = 0;
  logic [7:0]  mon_byte = '0;
  logic        tx_prev  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int cnt, input logic busy,
                                             input logic ovf, input logic irqen);
    logic [31:0] s;
    s = '0;
    s[ST_FULL]  = (cnt == DEPTH);
    s[ST_EMPTY] = (cnt == 0);
    s[ST_BUSY]  = busy;
    s[ST_OVF]   = ovf;
    s[7:4]      = (cnt > 15) ? 4'd15 : 4'(cnt);
    s[ST_IRQEN] = IRQ_BUILT & irqen;
    return s;
  endfunction

  // Line monitor: decodes 8N1 frames at bit centres and checks against exp_q.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_act = 1'b0;
        tx_prev = 1'b1;
      end else begin
        if (!mon_act) begin
          if (tx_prev && !tx) begin
            mon_act = 1'b1;
            mon_t   = 0;
            frames++;
            start_q.push_back(cyc);
          end
        end else begin
          mon_t++;
        end
        if (mon_act) begin
          if (mon_t == DIV / 2) begin
            check("start_bit", tx, 0);
          end else if (mon_t > DIV / 2 && mon_t < 9 * DIV && ((mon_t - DIV / 2) % DIV) == 0) begin
            mon_byte[(mon_t - DIV / 2) / DIV - 1] = tx;
          end else if (mon_t == 9 * DIV + DIV / 2) begin
            check("stop_bit", tx, 1);
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("tx_byte", mon_byte, exp_q.pop_front());
            mon_act = 1'b0;
          end
        end
        tx_prev = tx;
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_if.wr_en = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic accept);
    bus_write(UART_TXDATA_OFS, {24'hABCDEF, b});
    if (accept) begin
      exp_q.push_back(b);
      accepted++;
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_if.rd_en = 1'b1;
    bus_if.addr  = a;
    @(negedge clk);
    bus_if.rd_en = 1'b0;
    d = bus_if.rdata;
  endtask

  task automatic check_status(input string tag, input logic busy, input logic ovf, input logic irqen);
    logic [31:0] d;
    logic [31:0] e;
    e = exp_status(accepted - frames, busy, ovf, irqen);
    bus_read(UART_STATUS_OFS, d);
    check(tag, d, e);
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || mon_act) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, k < budget, 1);
    repeat (DIV + 4) @(negedge clk);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (frames < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, k < budget, 1);
  endtask

  initial begin
    logic [31:0] d;
    int f0;
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    bus_if.addr  = '0;
    bus_if.wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_rdata", bus_if.rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_status("reset_status", 0, 0, 0);

    // Single byte: latency and busy during the frame
    send(8'hA5, 1);
    check("lat_edge_n", tx, 1);
    @(negedge clk);
    check("lat_edge_n1", tx, 1);
    @(negedge clk);
    check("lat_edge_n2", tx, 0);
    repeat (3 * DIV) @(negedge clk);
    check_status("busy_mid_frame", 1, 0, 0);
    wait_drained("drain_a5", 3 * FRAME);
    check_status("idle_after_a5", 0, 0, 0);

    // Back-to-back frames with no idle gap
    start_q.delete();
    send(8'h01, 1);
    send(8'h02, 1);
    send(8'h03, 1);
    wait_drained("drain_three", 5 * FRAME);
    check("three_frames", start_q.size(), 3);
    if (start_q.size() == 3) begin
      check("gap_1_2", start_q[1] - start_q[0], FRAME);
      check("gap_2_3", start_q[2] - start_q[1], FRAME);
    end
    check_status("idle_after_three", 0, 0, 0);

    // Overflow: one byte goes to the shifter, eight fill the FIFO, tenth drops
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), i < 9);
    check_status("ovf_set", 1, 1, 0);
    bus_write(UART_STATUS_OFS, 32'h0000_0008);
    check_status("ovf_clear", 1, 0, 0);
    bus_read(UART_TXDATA_OFS, d);
    check("txdata_read_zero", d, 0);
    bus_read(UART_STATUS_OFS, d);
    bus_read(4'h8, d);
    check("unmapped_read_zero", d, 0);
    bus_write(4'hC, 32'h0000_0077);
    check_status("unmapped_write", 1, 0, 0);
    wait_drained("drain_ovf", 12 * FRAME);
    check_status("idle_after_ovf", 0, 0, 0);

    // Refill past pointer wrap while draining
    send(8'hC0, 1);
    repeat (3) @(negedge clk);
    for (int i = 1; i <= 8; i++) send(8'hC0 + 8'(i), 1);
    check_status("wrap_full", 1, 0, 0);
    f0 = frames;
    wait_frames("wrap_wait", f0 + 2, 4 * FRAME);
    repeat (2 * DIV) @(negedge clk);
    check_status("wrap_mid", 1, 0, 0);
    send(8'hC9, 1);
    send(8'hCA, 1);
    check_status("wrap_refull", 1, 0, 0);
    send(8'hCB, 0);
    check_status("wrap_ovf", 1, 1, 0);
    bus_write(UART_STATUS_OFS, 32'h0000_0008);
    wait_drained("drain_wrap", 14 * FRAME);
    check_status("wrap_idle", 0, 0, 0);

    // Reset in the middle of data bit 4
    send(8'h00, 1);
    send(8'h55, 1);
    f0 = frames;
    wait_frames("rst_wait", f0 + 1, 2 * FRAME);
    repeat (5 * DIV + DIV / 2) @(negedge clk);
    check("pre_reset_bit4", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_tx_high", tx, 1);
    check("async_rdata_zero", bus_if.rdata, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    accepted = 0;
    frames   = 0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_status("post_reset_status", 0, 0, 0);
    repeat (3 * DIV) @(negedge clk);
    check("no_stale_frame", frames, 0);
    send(8'h3C, 1);
    wait_drained("drain_post_reset", 3 * FRAME);
    check_status("post_reset_idle", 0, 0, 0);

    // Interrupt enable bit
    bus_write(UART_STATUS_OFS, 32'h0000_0100);
    check_status("irqen_bit", 0, 0, 1);
`ifdef UART_TX_IRQ_EN
    repeat (2) @(negedge clk);
    check("irq_idle_high", irq, 1);
    send(8'h5A, 1);
    f0 = frames;
    wait_frames("irq_wait", f0 + 1, 2 * FRAME);
    repeat (4 * DIV) @(negedge clk);
    check("irq_during_frame", irq, 0);
    begin
      int k;
      k = 0;
      while (!irq && k < 2 * FRAME) begin
        @(negedge clk);
        k++;
      end
      check("irq_rise_seen", irq, 1);
      if (start_q.size() != 0) check("irq_rise_time", cyc - start_q[start_q.size() - 1], FRAME);
    end
    wait_drained("drain_irq", 2 * FRAME);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
